image_stream_reader: RTL and testbench

Sequential read-out engine placed directly upstream of the image memory controller's read port. On a start pulse it sweeps the 18-bit pixel address space 0..NUM_PIXELS-1, absorbs the memory's one-cycle read latency, and presents each 8-bit pixel on a valid/ready stream toward the processing or display stage. A 2-entry buffer lets back-pressure stall the sweep without losing or duplicating pixels.

---
 rtl/image_pkg.sv | 13 +
 rtl/pixel_fifo2.sv | 53 +++++
 rtl/image_stream_reader.sv | 139 +++++++++++++
 tb/tb_image_stream_reader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared constants, pixel type and sweep FSM states for the image stream reader.
package image_pkg;

  localparam int IMG_NUM_PIXELS = 160000;
  localparam int IMG_WIDTH      = 400;
  localparam int IMG_HEIGHT     = 400;
  localparam int IMG_ADDR_W     = 18;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} stream_state_t;

endpackage

// File: rtl/pixel_fifo2.sv
// Two-entry pixel buffer between the memory read port and the output stream.
// The head entry stays put until popped, so a stalled consumer sees stable data.
module pixel_fifo2
  import image_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       push_last,
  input  logic       pop,
  output logic [1:0] count,
  output logic [7:0] head_data,
  output logic       head_last
);

  pixel_t     data_reg [2];
  logic [1:0] last_reg;
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg[0] <= '0;
      data_reg[1] <= '0;
      last_reg    <= '0;
      wr_ptr_reg  <= 1'b0;
      rd_ptr_reg  <= 1'b0;
      count_reg   <= 2'd0;
    end else begin
      if (push) begin
        data_reg[wr_ptr_reg] <= push_data;
        last_reg[wr_ptr_reg] <= push_last;
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign count     = count_reg;
  assign head_data = data_reg[rd_ptr_reg];
  // A stale last flag must not leak out once the buffer has emptied.
  assign head_last = last_reg[rd_ptr_reg] & (count_reg != 2'd0);

endmodule

// File: rtl/image_stream_reader.sv
// Sweeps the image memory 0..NUM_PIXELS-1 and streams pixels over valid/ready.
// Optional pixel coordinate outputs are enabled with IMAGE_STREAM_COORDS_EN.
module image_stream_reader #(
  parameter int NUM_PIXELS = image_pkg::IMG_NUM_PIXELS,
  parameter int IMG_WIDTH  = image_pkg::IMG_WIDTH,
  parameter int ADDR_W     = image_pkg::IMG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_a,
  input  logic [7:0]        mem_rd,
  output logic [7:0]        pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last
`ifdef IMAGE_STREAM_COORDS_EN
  ,
  output logic [8:0]        pix_x,
  output logic [8:0]        pix_y
`endif
);
  import image_pkg::*;

  stream_state_t     state_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [ADDR_W-1:0] mem_a_reg;
  logic              inflight_reg;
  logic              inflight_last_reg;
  logic              busy_reg;
  logic              done_reg;

  logic [1:0]        count;
  pixel_t            head_data;
  logic              head_last;
  logic              pop;
  logic              issue;
  logic              last_addr;
  logic              accept_start;
  logic [2:0]        occupancy;

  assign pix_valid    = (count != 2'd0);
  assign pop          = pix_valid & pix_ready;
  // Occupancy the buffer will have after this edge; a read issued now lands one edge later.
  assign occupancy    = 3'(count) + 3'(inflight_reg) - 3'(pop);
  assign issue        = (state_reg == FETCH) && (occupancy < 3'd2);
  assign last_addr    = (rd_addr_reg == ADDR_W'(NUM_PIXELS - 1));
  assign accept_start = (state_reg == IDLE) && start && !done_reg;
  assign mem_a        = issue ? rd_addr_reg : mem_a_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= IDLE;
      rd_addr_reg       <= '0;
      mem_a_reg         <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
    end else begin
      done_reg          <= 1'b0;
      inflight_reg      <= issue;
      inflight_last_reg <= issue && last_addr;
      if (issue) begin
        mem_a_reg <= rd_addr_reg;
        if (!last_addr) begin
          rd_addr_reg <= rd_addr_reg + ADDR_W'(1);
        end
      end
      case (state_reg)
        IDLE: begin
          if (accept_start) begin
            state_reg   <= FETCH;
            rd_addr_reg <= '0;
            busy_reg    <= 1'b1;
          end
        end
        FETCH: begin
          if (issue && last_addr) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && head_last) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  pixel_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_reg),
    .push_data (mem_rd),
    .push_last (inflight_last_reg),
    .pop       (pop),
    .count     (count),
    .head_data (head_data),
    .head_last (head_last)
  );

  assign pix_data = head_data;
  assign pix_last = head_last;
  assign busy     = busy_reg;
  assign done     = done_reg;

`ifdef IMAGE_STREAM_COORDS_EN
  logic [8:0] x_reg;
  logic [8:0] y_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (accept_start) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (pop) begin
      if (x_reg == 9'(IMG_WIDTH - 1)) begin
        x_reg <= '0;
        y_reg <= y_reg + 9'd1;
      end else begin
        x_reg <= x_reg + 9'd1;
      end
    end
  end

  assign pix_x = x_reg;
  assign pix_y = y_reg;
`endif

endmodule

// File: tb/tb_image_stream_reader.sv
// Scoreboard bench for image_stream_reader with a 16-pixel, 4-wide frame.
// Stimulus pushes expected pixels; a negedge monitor pops and compares on each handshake.
module tb_image_stream_reader;

  localparam int NP = 16;
  localparam int W  = 4;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic [8:0] x;
    logic [8:0] y;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pix_ready = 1'b0;
  logic        busy, done, pix_valid, pix_last;
  logic [17:0] mem_a;
  logic [7:0]  mem_rd = 8'h00;
  logic [7:0]  pix_data;
`ifdef IMAGE_STREAM_COORDS_EN
  logic [8:0]  pix_x, pix_y;
`endif

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   first_cyc = 0;
  int   frame_pix = 0;
  int   rdy_mode = 0;
  int   bp_lo = 0;
  int   bp_hi = -1;
  exp_t q[$];
  exp_t e;

  image_stream_reader #(.NUM_PIXELS(NP), .IMG_WIDTH(W), .ADDR_W(18)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_a     (mem_a),
    .mem_rd    (mem_rd),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_last  (pix_last)
`ifdef IMAGE_STREAM_COORDS_EN
    ,
    .pix_x     (pix_x),
    .pix_y     (pix_y)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: data = address + 0x10, one cycle after the address.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    mem_rd <= 8'(mem_a) + 8'h10;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) pix_ready = 1'($urandom_range(0, 1));
      else               pix_ready = !(cyc >= bp_lo && cyc <= bp_hi);
    end
  end

  // Monitor
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_stall) begin
          check("stall_valid", 32'(pix_valid), 32'd1);
          check("stall_data", 32'(pix_data), 32'(prev_data));
          check("stall_last", 32'(pix_last), 32'(prev_last));
        end
        if (pix_valid && pix_ready) begin
          frame_pix++;
          if (frame_pix == 1) first_cyc = cyc;
          $display("pix %0d data=0x%02h last=%0b cyc=%0d", frame_pix - 1, pix_data, pix_last, cyc);
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_pixel: got 0x%0h, expected no pixel (cycle %0d)", pix_data, cyc);
          end else begin
            e = q.pop_front();
            check("pix_data", 32'(pix_data), 32'(e.d));
            check("pix_last", 32'(pix_last), 32'(e.l));
`ifdef IMAGE_STREAM_COORDS_EN
            check("pix_x", 32'(pix_x), 32'(e.x));
            check("pix_y", 32'(pix_y), 32'(e.y));
`endif
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          $display("done cyc=%0d", cyc);
          check("done_queue_empty", 32'(q.size()), 32'd0);
          check("busy_at_done", 32'(busy), 32'd0);
        end
      end
      prev_stall = !rst && pix_valid && !pix_ready;
      prev_data  = pix_data;
      prev_last  = pix_last;
    end
  end

  task automatic start_frame(output int n);
    exp_t x;
    for (int i = 0; i < NP; i++) begin
      x.d = 8'h10 + 8'(i);
      x.l = (i == NP - 1);
      x.x = 9'(i % W);
      x.y = 9'(i / W);
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    start     = 1'b1;
    frame_pix = 0;
    n         = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("mem_a_first", 32'(mem_a), 32'd0);
  endtask

  task automatic wait_done(input int d0, input int budget);
    int i;
    i = 0;
    while (done_cnt == d0 && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("done_seen", 32'(done_cnt > d0), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_data"}, 32'(pix_data), 32'd0);
    check({tag, "_last"}, 32'(pix_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_mem_a"}, 32'(mem_a), 32'd0);
`ifdef IMAGE_STREAM_COORDS_EN
    check({tag, "_x"}, 32'(pix_x), 32'd0);
    check({tag, "_y"}, 32'(pix_y), 32'd0);
`endif
  endtask

  initial begin
    int n;
    int d0;
    int changes;
    int bad;
    int i;
    logic [17:0] prev_a;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (pix_valid || busy || done || mem_a != 18'd0) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);
    @(posedge clk);
    #1;

    // Full throughput
    rdy_mode = 0;
    d0 = done_cnt;
    start_frame(n);
    wait_done(d0, 100);
    check("first_pixel_cycle", 32'(first_cyc), 32'(n + 3));
    check("done_cycle", 32'(done_cyc), 32'(n + 19));
    check("frame_pixels_full", 32'(frame_pix), 32'd16);

    // Back-pressure window four cycles after start, six cycles long
    repeat (3) @(posedge clk);
    #1;
    d0 = done_cnt;
    start_frame(n);
    bp_lo   = n + 4;
    bp_hi   = n + 9;
    changes = 0;
    prev_a  = mem_a;
    while (cyc <= bp_hi) begin
      @(negedge clk);
      if (cyc >= bp_lo && cyc <= bp_hi && mem_a != prev_a) changes++;
      prev_a = mem_a;
    end
    check("stall_reads_le2", 32'(changes <= 2), 32'd1);
    wait_done(d0, 100);
    check("frame_pixels_bp", 32'(frame_pix), 32'd16);
    bp_lo = 0;
    bp_hi = -1;

    // Random ready over three frames
    rdy_mode = 1;
    for (int f = 0; f < 3; f++) begin
      repeat (2) @(posedge clk);
      #1;
      d0 = done_cnt;
      start_frame(n);
      wait_done(d0, 400);
      check("frame_pixels_rand", 32'(frame_pix), 32'd16);
      repeat (3) @(posedge clk);
      #1;
      check("busy_between_frames", 32'(busy), 32'd0);
      check("one_done_per_frame", 32'(done_cnt), 32'(d0 + 1));
    end
    rdy_mode = 0;

    // Starts while busy and in the done cycle are ignored
    repeat (3) @(posedge clk);
    #1;
    d0 = done_cnt;
    start_frame(n);
    while (cyc < n + 6) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (cyc < n + 19) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    check("done_in_start_cycle", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("no_restart_busy", 32'(busy), 32'd0);
    check("no_restart_done", 32'(done_cnt), 32'(d0 + 1));
    check("no_restart_pixels", 32'(frame_pix), 32'd16);

    // Reset right after the 7th handshake
    d0 = done_cnt;
    start_frame(n);
    i = 0;
    while (frame_pix < 7 && i < 100) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("reached_7th_pixel", 32'(frame_pix >= 7), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (pix_valid || busy) bad++;
    end
    check("quiet_after_reset", 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    d0 = done_cnt;
    start_frame(n);
    wait_done(d0, 100);
    check("frame_pixels_after_reset", 32'(frame_pix), 32'd16);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
